// File: rtl/dmem_pkg.sv
// dmem_pkg: address map, STATUS layout and access decode for dmem_responder
package dmem_pkg;

    localparam logic [7:0] REGION_RAM  = 8'h00;
    localparam logic [7:0] REGION_MMIO = 8'h02;

    localparam logic [23:0] OFF_TXDATA = 24'h00_0000;
    localparam logic [23:0] OFF_STATUS = 24'h00_0004;
    localparam logic [23:0] OFF_CYCLES = 24'h00_0008;

    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_OVF      = 2;
    localparam int ST_COUNT_LO = 4;
    localparam int ST_COUNT_HI = 7;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_TXDATA,
        SEL_STATUS,
        SEL_CYCLES
    } sel_e;

    // Byte lanes are ignored: every access is treated as a whole word.
    function automatic sel_e decode(input logic [31:0] addr, input logic [31:0] ram_bytes);
        logic [23:0] off;
        off = {addr[23:2], 2'b00};
        if (addr[31:24] == REGION_RAM) return ({8'h00, addr[23:0]} < ram_bytes) ? SEL_RAM : SEL_NONE;
        if (addr[31:24] != REGION_MMIO) return SEL_NONE;
        return off == OFF_TXDATA ? SEL_TXDATA :
               off == OFF_STATUS ? SEL_STATUS :
               off == OFF_CYCLES ? SEL_CYCLES : SEL_NONE;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core load/store bus plus the transmit byte stream
interface dmem_responder_if;

    logic        MemWrite;
    logic [31:0] Mem_WrAddr;
    logic [31:0] Mem_WrData;
    logic [31:0] ReadData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output MemWrite, Mem_WrAddr, Mem_WrData, tx_ready,
        input  ReadData, tx_data, tx_valid
    );

    modport slave (
        input  MemWrite, Mem_WrAddr, Mem_WrData, tx_ready,
        output ReadData, tx_data, tx_valid
    );

endinterface

// File: rtl/dmem_responder_tx_fifo.sv
// tx_fifo: byte FIFO with registered head, push-through-pop when full
module tx_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic [3:0] count,
    output logic       full,
    output logic       empty
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rptr, wptr;
    logic          do_push, do_pop;

    assign empty   = count == 4'd0;
    assign full    = count == 4'(FIFO_DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? 8'h00 : mem[rptr];

    // Pointers and occupancy; a full FIFO accepts a push only alongside a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= 4'd0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + {3'b000, do_push} - {3'b000, do_pop};
        end
    end

    // Storage is not reset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM plus MMIO window (TX FIFO, STATUS, CYCLES) for the core's data bus
module dmem_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input logic              adc_sck,
    input logic              reset,
    dmem_responder_if.slave  bus
);

    import dmem_pkg::*;

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0] ram [RAM_WORDS];
    sel_e        sel;
    logic        push, pop, full, empty, ovf;
    logic [3:0]  count;
    logic [7:0]  head;
    logic [31:0] cycles, status;
    logic [AW-1:0] idx;

    assign sel  = decode(bus.Mem_WrAddr, RAM_WORDS * 4);
    assign idx  = bus.Mem_WrAddr[AW+1:2];
    assign push = bus.MemWrite && sel == SEL_TXDATA;
    assign pop  = bus.tx_valid && bus.tx_ready;

    assign bus.tx_valid = !empty;
    assign bus.tx_data  = head;

    tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (adc_sck),
        .rst       (reset),
        .push      (push),
        .push_data (bus.Mem_WrData[7:0]),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // RAM keeps its contents through reset; stores land on the edge.
    always_ff @(posedge adc_sck) begin
        if (bus.MemWrite && sel == SEL_RAM) ram[idx] <= bus.Mem_WrData;
    end

    // Sticky overflow: set by a push dropped on a full FIFO, cleared by any STATUS write.
    always_ff @(posedge adc_sck) begin
        if (reset) ovf <= 1'b0;
        else if (bus.MemWrite && sel == SEL_STATUS) ovf <= 1'b0;
        else if (push && full && !pop) ovf <= 1'b1;
    end

    // Free-running cycle counter, loadable through the CYCLES register.
    always_ff @(posedge adc_sck) begin
        if (reset) cycles <= 32'd0;
        else if (bus.MemWrite && sel == SEL_CYCLES) cycles <= bus.Mem_WrData;
        else cycles <= cycles + 32'd1;
    end

    // STATUS word assembled from FIFO flags, overflow and occupancy.
    always_comb begin
        status = 32'd0;
        status[ST_EMPTY] = empty;
        status[ST_FULL] = full;
        status[ST_OVF] = ovf;
        status[ST_COUNT_HI:ST_COUNT_LO] = count;
    end

    assign bus.ReadData = sel == SEL_RAM    ? ram[idx] :
                          sel == SEL_STATUS ? status   :
                          sel == SEL_CYCLES ? cycles   : 32'd0;

endmodule
